// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master, one-slave arbiter for the picorv32 native bus.
// Master 0 is the CPU and master 1 is the DMA/USB engine. Grants are held for a
// whole transaction, until the slave's ready. One IDLE bubble separates grants.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a stalled slave
// forces completion after TIMEOUT_CYCLES. The forced completion returns
// all-ones read data and pulses bus_err.
//
// state | meaning
// IDLE  | no owner, slave port quiet, choosing the next owner
// OWN0  | master 0 owns the slave port until s_ready (or timeout)
// OWN1  | master 1 owns the slave port until s_ready (or timeout)
module mem_bus_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic [1:0]  grant,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] grant_q;
    logic       last;
    logic       own0;
    logic       own1;
    logic       timeout;
    logic       done;
    logic       pick1;

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Count stalled owning cycles; the counter sits at zero in IDLE.
    // So it starts from zero on every new grant.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt <= 8'd0;
        end else if (state == IDLE) begin
            wait_cnt <= 8'd0;
        end else if (!s_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // A ready from the slave in the expiry cycle takes precedence over the timeout.
    assign timeout = (own0 || own1) && !s_ready && (wait_cnt == 8'(TIMEOUT_CYCLES));
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign done    = (own0 || own1) && (s_ready || timeout);
    assign bus_err = timeout;

    // When both masters contend, m1 wins only in round-robin mode with m0 served last.
    assign pick1 = m1_valid && (!m0_valid || ((FIXED_PRIORITY == 0) && !last));

    // Ownership FSM; the grant register tracks the state one-hot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            grant_q <= 2'b00;
            last    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        if (pick1) begin
                            state   <= OWN1;
                            grant_q <= 2'b10;
                        end else begin
                            state   <= OWN0;
                            grant_q <= 2'b01;
                        end
                    end
                end
                OWN0, OWN1: begin
                    if (done) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                        last    <= own1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign grant = grant_q;

    // The slave port follows the owner; it is driven to zero when there is no owner.
    always_comb begin
        s_valid = own0 || own1;
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        s_wstrb = 4'd0;
        if (own0) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else if (own1) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end
    end

    // Completion and read data pass straight through to the owner only.
    always_comb begin
        m0_ready = own0 && done;
        m1_ready = own1 && done;
        m0_rdata = 32'd0;
        m1_rdata = 32'd0;
        if (own0) begin
            m0_rdata = timeout ? 32'hFFFF_FFFF : s_rdata;
        end
        if (own1) begin
            m1_rdata = timeout ? 32'hFFFF_FFFF : s_rdata;
        end
    end

endmodule
